// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx -- device-side PS/2 keyboard transmitter (keyboard emulator).
//
// Scancode bytes enter a small FIFO over a valid/ready handshake. Each byte is
// then serialised as an 11-bit PS/2 frame on self-generated ps2_clk/ps2_data:
// start 0, data LSB first, odd parity, stop 1. An idle gap follows every frame.
// The outputs can drive a host receiver such as ps2_keyboard directly.
//
// Optional feature, compile-time macro PS2_TX_BREAK_EN:
//   defined   - each FIFO entry carries a break flag. A flagged entry first
//               sends a 0xF0 frame plus gap, then the data frame plus gap.
//   undefined - in_brk is ignored and every entry yields exactly one frame.
module ps2_kbd_tx #(
    parameter int CLK_DIV    = 50,   // clk cycles per ps2_clk half-period, >= 2
    parameter int GAP_CYCLES = 200,  // idle cycles after each stop bit, >= 1
    parameter int DEPTH      = 8     // FIFO depth, power of two, >= 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] in_data,
    input  logic       in_brk,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       overflow
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};

`ifdef PS2_TX_BREAK_EN
    localparam int FW = 9;
`else
    localparam int FW = 8;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BIT_HI = 2'd1,
        BIT_LO = 2'd2,
        GAP    = 2'd3
    } state_t;

    // PS/2 parity is odd: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Frame bits in transmit order, bit 0 first: start, data[0..7], parity, stop.
    function automatic logic [10:0] build_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d, 1'b0};
    endfunction

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [FW-1:0] mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic          overflow_r;
    logic          full_s;
    logic          empty_s;
    logic          wr_en_s;
    logic          pop_s;
    logic [FW-1:0] wr_entry_s;
    logic [FW-1:0] head_s;

    // The extra pointer MSB tells full (MSBs differ) from empty (MSBs equal).
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign wr_en_s = in_valid && !full_s;
    assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

`ifdef PS2_TX_BREAK_EN
    assign wr_entry_s = {in_brk, in_data};
`else
    logic unused_brk_s;
    assign unused_brk_s = in_brk;
    assign wr_entry_s   = in_data;
`endif

    // FIFO storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_entry_s;
        end
    end

    // FIFO pointers and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r   <= {(AW+1){1'b0}};
            rd_ptr_r   <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (in_valid && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame serialiser FSM
    // ------------------------------------------------------------------
    state_t           state_r,    state_nx_s;
    logic [CNT_W-1:0] cnt_r,      cnt_nx_s;
    logic [3:0]       bit_idx_r,  bit_idx_nx_s;
    logic [10:0]      frame_r,    frame_nx_s;
    logic             ps2_clk_r,  ps2_clk_nx_s;
    logic             ps2_data_r, ps2_data_nx_s;
`ifdef PS2_TX_BREAK_EN
    logic             pend_r,     pend_nx_s;
    logic [7:0]       hold_r,     hold_nx_s;
`endif

    // State, counters, shift register and line drivers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            bit_idx_r  <= 4'd0;
            frame_r    <= 11'h7FF;
            ps2_clk_r  <= 1'b1;
            ps2_data_r <= 1'b1;
`ifdef PS2_TX_BREAK_EN
            pend_r     <= 1'b0;
            hold_r     <= 8'h00;
`endif
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            bit_idx_r  <= bit_idx_nx_s;
            frame_r    <= frame_nx_s;
            ps2_clk_r  <= ps2_clk_nx_s;
            ps2_data_r <= ps2_data_nx_s;
`ifdef PS2_TX_BREAK_EN
            pend_r     <= pend_nx_s;
            hold_r     <= hold_nx_s;
`endif
        end
    end

    // Next-state logic; line values are decided one cycle ahead so the
    // outputs stay registered and data only moves on a ps2_clk rising edge.
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r;
        bit_idx_nx_s  = bit_idx_r;
        frame_nx_s    = frame_r;
        ps2_clk_nx_s  = ps2_clk_r;
        ps2_data_nx_s = ps2_data_r;
        pop_s         = 1'b0;
`ifdef PS2_TX_BREAK_EN
        pend_nx_s     = pend_r;
        hold_nx_s     = hold_r;
`endif
        case (state_r)
            IDLE: begin
                cnt_nx_s      = CNT_ZERO;
                bit_idx_nx_s  = 4'd0;
                ps2_clk_nx_s  = 1'b1;
                ps2_data_nx_s = 1'b1;
`ifdef PS2_TX_BREAK_EN
                if (pend_r) begin
                    // Second half of a break entry: the held data byte.
                    pend_nx_s     = 1'b0;
                    frame_nx_s    = build_frame(hold_r);
                    ps2_data_nx_s = 1'b0;
                    state_nx_s    = BIT_HI;
                end else if (!empty_s) begin
                    pop_s         = 1'b1;
                    ps2_data_nx_s = 1'b0;
                    state_nx_s    = BIT_HI;
                    if (head_s[8]) begin
                        pend_nx_s  = 1'b1;
                        hold_nx_s  = head_s[7:0];
                        frame_nx_s = build_frame(8'hF0);
                    end else begin
                        frame_nx_s = build_frame(head_s[7:0]);
                    end
                end else begin
                    state_nx_s = IDLE;
                end
`else
                if (!empty_s) begin
                    pop_s         = 1'b1;
                    frame_nx_s    = build_frame(head_s);
                    ps2_data_nx_s = 1'b0;
                    state_nx_s    = BIT_HI;
                end else begin
                    state_nx_s = IDLE;
                end
`endif
            end
            BIT_HI: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_nx_s     = CNT_ZERO;
                    ps2_clk_nx_s = 1'b0;
                    state_nx_s   = BIT_LO;
                end else begin
                    cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            BIT_LO: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_nx_s     = CNT_ZERO;
                    ps2_clk_nx_s = 1'b1;
                    if (bit_idx_r < 4'd10) begin
                        bit_idx_nx_s  = bit_idx_r + 4'd1;
                        frame_nx_s    = {1'b1, frame_r[10:1]};
                        ps2_data_nx_s = frame_r[1];
                        state_nx_s    = BIT_HI;
                    end else begin
                        ps2_data_nx_s = 1'b1;
                        state_nx_s    = GAP;
                    end
                end else begin
                    cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            GAP: begin
                ps2_clk_nx_s  = 1'b1;
                ps2_data_nx_s = 1'b1;
                if (cnt_r == GAP_LAST) begin
                    cnt_nx_s   = CNT_ZERO;
                    state_nx_s = IDLE;
                end else begin
                    cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                cnt_nx_s      = CNT_ZERO;
                bit_idx_nx_s  = 4'd0;
                ps2_clk_nx_s  = 1'b1;
                ps2_data_nx_s = 1'b1;
                state_nx_s    = IDLE;
            end
        endcase
    end

    assign ps2_clk  = ps2_clk_r;
    assign ps2_data = ps2_data_r;
    assign in_ready = !full_s;
    assign overflow = overflow_r;
`ifdef PS2_TX_BREAK_EN
    assign busy = (state_r != IDLE) || !empty_s || pend_r;
`else
    assign busy = (state_r != IDLE) || !empty_s;
`endif

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx with CLK_DIV=4, GAP_CYCLES=8, DEPTH=8.
// Outputs are sampled on the clk falling edge; a small host-side monitor
// captures ps2_data at every ps2_clk falling edge.
module tb_ps2_kbd_tx;

    logic       clk;
    logic       resetn;
    logic [7:0] in_data;
    logic       in_brk;
    logic       in_valid;
    logic       in_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic bits_q[$];
    int   run_q[$];
    int   busy_cnt;
    int   tail_run;
    logic obs_timeout;

    ps2_kbd_tx #(.CLK_DIV(4), .GAP_CYCLES(8), .DEPTH(8)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_data  (in_data),
        .in_brk   (in_brk),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One accepted write; returns on the falling edge after the write edge.
    task automatic push_byte(input logic [7:0] b, input logic brk);
        @(negedge clk);
        in_data  = b;
        in_brk   = brk;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_brk   = 1'b0;
    endtask

    // Sample every falling clk edge until busy drops (or budget expires).
    // Records captured bits, lengths of all-high runs before each start bit,
    // the count of busy samples and the high run after the last frame.
    task automatic observe(input int max_cycles);
        logic prev_clk;
        logic prev_data;
        int   cur_run;
        int   c;
        logic done;
        bits_q.delete();
        run_q.delete();
        busy_cnt  = 0;
        tail_run  = 0;
        prev_clk  = 1'b1;
        prev_data = 1'b1;
        cur_run   = 0;
        c         = 0;
        done      = 1'b0;
        while (!done && c < max_cycles) begin
            if (busy !== 1'b1) begin
                tail_run = cur_run;
                done     = 1'b1;
            end else begin
                busy_cnt++;
                if (prev_clk && !ps2_clk) bits_q.push_back(ps2_data);
                if (ps2_clk && ps2_data) begin
                    cur_run++;
                end else begin
                    if (!ps2_data && prev_data && prev_clk && cur_run > 0)
                        run_q.push_back(cur_run);
                    cur_run = 0;
                end
                prev_clk  = ps2_clk;
                prev_data = ps2_data;
                @(negedge clk);
                c++;
            end
        end
        obs_timeout = !done;
    endtask

    function automatic logic [10:0] frame_at(input int f);
        logic [10:0] v;
        for (int k = 0; k < 11; k++) v[k] = bits_q[f*11 + k];
        return v;
    endfunction

    task automatic test_reset;
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_brk   = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++; if (ps2_clk !== 1'b1)  begin n_errors++; $display("FAIL reset_clk got=%b exp=1", ps2_clk); end
        n_checks++; if (ps2_data !== 1'b1) begin n_errors++; $display("FAIL reset_data got=%b exp=1", ps2_data); end
        n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || ps2_clk !== 1'b1) begin n_errors++; $display("FAIL idle_after_reset busy=%b clk=%b exp busy=0 clk=1", busy, ps2_clk); end
    endtask

    task automatic test_single_frame;
        push_byte(8'h1C, 1'b0);
        observe(300);
        n_checks++; if (obs_timeout !== 1'b0) begin n_errors++; $display("FAIL single_timeout got=%b exp=0", obs_timeout); end
        n_checks++; if (bits_q.size() != 11) begin n_errors++; $display("FAIL single_nbits got=%0d exp=11", bits_q.size()); end
        if (bits_q.size() == 11) begin
            n_checks++; if (frame_at(0) !== 11'b10000111000) begin n_errors++; $display("FAIL single_bits got=%b exp=%b", frame_at(0), 11'b10000111000); end
        end
        // one IDLE sample before the start bit: data falls 2 edges after the write edge
        n_checks++; if (run_q.size() != 1 || run_q[0] != 1) begin n_errors++; $display("FAIL single_latency got_runs=%0d exp=1 run of 1", run_q.size()); end
        n_checks++; if (tail_run != 8)   begin n_errors++; $display("FAIL single_gap got=%0d exp=8", tail_run); end
        n_checks++; if (busy_cnt != 97)  begin n_errors++; $display("FAIL single_busy_len got=%0d exp=97", busy_cnt); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        in_data = 8'h00; in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        observe(500);
        n_checks++; if (obs_timeout !== 1'b0) begin n_errors++; $display("FAIL b2b_timeout got=%b exp=0", obs_timeout); end
        n_checks++; if (bits_q.size() != 22) begin n_errors++; $display("FAIL b2b_nbits got=%0d exp=22", bits_q.size()); end
        if (bits_q.size() == 22) begin
            n_checks++; if (frame_at(0) !== 11'b11000000000) begin n_errors++; $display("FAIL b2b_frame0 got=%b exp=%b", frame_at(0), 11'b11000000000); end
            n_checks++; if (frame_at(1) !== 11'b11111111110) begin n_errors++; $display("FAIL b2b_frame1 got=%b exp=%b", frame_at(1), 11'b11111111110); end
        end
        n_checks++; if (run_q.size() != 1 || run_q[0] != 9) begin n_errors++; $display("FAIL b2b_interframe runs=%0d exp=1 run of 9", run_q.size()); end
        n_checks++; if (tail_run != 8)  begin n_errors++; $display("FAIL b2b_gap got=%0d exp=8", tail_run); end
        n_checks++; if (busy_cnt != 193) begin n_errors++; $display("FAIL b2b_busy_len got=%0d exp=193", busy_cnt); end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_byte [9];
        logic       exp_par  [9];
        exp_byte = '{8'h10, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
        exp_par  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        push_byte(8'h10, 1'b0);
        fork
            observe(2000);
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 9; i++) begin
                    n_checks++;
                    if (in_ready !== ((i < 8) ? 1'b1 : 1'b0)) begin
                        n_errors++; $display("FAIL ovf_ready write=%0d got=%b exp=%b", i, in_ready, (i < 8) ? 1'b1 : 1'b0);
                    end
                    in_data  = 8'h20 + 8'(i);
                    in_valid = 1'b1;
                    @(negedge clk);
                end
                in_valid = 1'b0;
                n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
            end
        join
        n_checks++; if (obs_timeout !== 1'b0) begin n_errors++; $display("FAIL ovf_timeout got=%b exp=0", obs_timeout); end
        n_checks++; if (bits_q.size() != 99) begin n_errors++; $display("FAIL ovf_nbits got=%0d exp=99", bits_q.size()); end
        if (bits_q.size() == 99) begin
            for (int f = 0; f < 9; f++) begin
                n_checks++;
                if (frame_at(f) !== {1'b1, exp_par[f], exp_byte[f], 1'b0}) begin
                    n_errors++; $display("FAIL ovf_frame%0d got=%b exp=%b", f, frame_at(f), {1'b1, exp_par[f], exp_byte[f], 1'b0});
                end
            end
        end
        n_checks++; if (busy_cnt != 873) begin n_errors++; $display("FAIL ovf_busy_len got=%0d exp=873", busy_cnt); end
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_reset_mid_frame;
        int   falls;
        int   cyc;
        int   bad;
        logic prev;
        push_byte(8'h55, 1'b0);
        falls = 0;
        cyc   = 0;
        prev  = ps2_clk;
        while (falls < 6 && cyc < 300) begin
            @(negedge clk);
            if (prev && !ps2_clk) falls++;
            prev = ps2_clk;
            cyc++;
        end
        n_checks++; if (falls != 6) begin n_errors++; $display("FAIL midrst_reach got=%0d exp=6 falls", falls); end
        in_data = 8'hAA; in_valid = 1'b1;  // also queue a byte that reset must discard
        @(negedge clk);
        in_valid = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        n_checks++; if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin n_errors++; $display("FAIL midrst_lines clk=%b data=%b exp=1 1", ps2_clk, ps2_data); end
        n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL midrst_ovf got=%b exp=0", overflow); end
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL midrst_quiet got=%0d active samples exp=0", bad); end
    endtask

    task automatic test_break;
`ifdef PS2_TX_BREAK_EN
        push_byte(8'h1C, 1'b1);
        observe(600);
        n_checks++; if (obs_timeout !== 1'b0) begin n_errors++; $display("FAIL brk_timeout got=%b exp=0", obs_timeout); end
        n_checks++; if (bits_q.size() != 22) begin n_errors++; $display("FAIL brk_nbits got=%0d exp=22", bits_q.size()); end
        if (bits_q.size() == 22) begin
            n_checks++; if (frame_at(0) !== 11'b11111100000) begin n_errors++; $display("FAIL brk_f0 got=%b exp=%b", frame_at(0), 11'b11111100000); end
            n_checks++; if (frame_at(1) !== 11'b10000111000) begin n_errors++; $display("FAIL brk_data got=%b exp=%b", frame_at(1), 11'b10000111000); end
        end
        n_checks++; if (busy_cnt != 194) begin n_errors++; $display("FAIL brk_busy_len got=%0d exp=194", busy_cnt); end
`else
        push_byte(8'h1C, 1'b1);
        observe(600);
        n_checks++; if (obs_timeout !== 1'b0) begin n_errors++; $display("FAIL nobrk_timeout got=%b exp=0", obs_timeout); end
        n_checks++; if (bits_q.size() != 11) begin n_errors++; $display("FAIL nobrk_nbits got=%0d exp=11", bits_q.size()); end
        if (bits_q.size() == 11) begin
            n_checks++; if (frame_at(0) !== 11'b10000111000) begin n_errors++; $display("FAIL nobrk_bits got=%b exp=%b", frame_at(0), 11'b10000111000); end
        end
        n_checks++; if (busy_cnt != 97) begin n_errors++; $display("FAIL nobrk_busy_len got=%0d exp=97", busy_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_break();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
